// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target bridging bus writes/reads onto a simple register port
// Optional 3-sample majority glitch filter on the synchronized lines: I2C_TGT_GLITCH_FILTER_EN
module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR    = 7'h3C,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ADDR      = 4'd1;
  localparam logic [3:0] S_ADDR_ACK  = 4'd2;
  localparam logic [3:0] S_PTR       = 4'd3;
  localparam logic [3:0] S_PTR_ACK   = 4'd4;
  localparam logic [3:0] S_WDATA     = 4'd5;
  localparam logic [3:0] S_WDATA_ACK = 4'd6;
  localparam logic [3:0] S_RDATA     = 4'd7;
  localparam logic [3:0] S_RDATA_ACK = 4'd8;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_f, sda_f, scl_q, sda_q;
  logic scl_rise, scl_fall, start, stop;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
    end
  end

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

`ifdef I2C_TGT_GLITCH_FILTER_EN
  logic [2:0] scl_hist, sda_hist;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[1] & v[2]) | (v[0] & v[2]);
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scl_hist <= '1;
      sda_hist <= '1;
    end else begin
      scl_hist <= {scl_hist[1:0], scl_s};
      sda_hist <= {sda_hist[1:0], sda_s};
    end
  end

  assign scl_f = maj3(scl_hist);
  assign sda_f = maj3(sda_hist);
`else
  assign scl_f = scl_s;
  assign sda_f = sda_s;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  assign scl_rise = scl_f & ~scl_q;
  assign scl_fall = ~scl_f & scl_q;
  assign start    = scl_f & scl_q & sda_q & ~sda_f;
  assign stop     = scl_f & scl_q & ~sda_q & sda_f;

  logic [3:0] state;
  logic [3:0] cnt;
  logic [6:0] shift;
  logic       ack_phase;
  logic       rw;
  logic       byte_done;
  logic [7:0] byte_val;

  assign byte_done = scl_rise && (cnt == 4'd7);
  assign byte_val  = {shift, sda_f};

  // ack_phase: 0 = waiting for the fall that starts our ACK, 1 = ACK on the bus.
  // In RDATA_ACK it instead marks that the master ACKed and the next byte is due.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      sda_oe    <= 1'b0;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
      busy      <= 1'b0;
      cnt       <= 4'd0;
      shift     <= 7'd0;
      ack_phase <= 1'b0;
      rw        <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      if (start) begin
        state     <= S_ADDR;
        cnt       <= 4'd0;
        sda_oe    <= 1'b0;
        ack_phase <= 1'b0;
        busy      <= 1'b1;
      end else if (stop) begin
        state  <= S_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          S_ADDR, S_PTR, S_WDATA: begin
            if (scl_rise) begin
              shift <= {shift[5:0], sda_f};
              cnt   <= cnt + 4'd1;
            end
            if (byte_done) begin
              ack_phase <= 1'b0;
              if (state == S_ADDR) begin
                if (shift == DEV_ADDR) begin
                  state <= S_ADDR_ACK;
                  rw    <= sda_f;
                end else begin
                  state <= S_IDLE;
                end
              end else if (state == S_PTR) begin
                reg_addr <= byte_val;
                state    <= S_PTR_ACK;
              end else begin
                reg_wdata <= byte_val;
                reg_we    <= 1'b1;
                state     <= S_WDATA_ACK;
              end
            end
          end
          S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_oe    <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
                cnt       <= 4'd0;
                if (state == S_ADDR_ACK && rw) begin
                  shift  <= reg_rdata[6:0];
                  sda_oe <= ~reg_rdata[7];
                  state  <= S_RDATA;
                end else begin
                  sda_oe <= 1'b0;
                  if (state == S_WDATA_ACK) reg_addr <= reg_addr + 8'd1;
                  state <= (state == S_ADDR_ACK) ? S_PTR : S_WDATA;
                end
              end
            end
          end
          S_RDATA: begin
            if (scl_rise) begin
              cnt <= cnt + 4'd1;
            end else if (scl_fall) begin
              if (cnt == 4'd8) begin
                sda_oe    <= 1'b0;
                ack_phase <= 1'b0;
                state     <= S_RDATA_ACK;
              end else begin
                sda_oe <= ~shift[6];
                shift  <= {shift[5:0], 1'b0};
              end
            end
          end
          S_RDATA_ACK: begin
            if (scl_rise) begin
              if (!sda_f) begin
                reg_addr  <= reg_addr + 8'd1;
                ack_phase <= 1'b1;
              end else begin
                state <= S_IDLE;
              end
            end else if (scl_fall && ack_phase) begin
              shift     <= reg_rdata[6:0];
              sda_oe    <= ~reg_rdata[7];
              cnt       <= 4'd0;
              ack_phase <= 1'b0;
              state     <= S_RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb/tb_i2c_target_regs.sv - directed bus transactions against a transaction-level register-port model
// Glitch-filter scenario runs only when I2C_TGT_GLITCH_FILTER_EN is defined.
module tb_i2c_target_regs;
  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we;
  logic       busy;

  int passed = 0;
  int total = 0;

  logic [7:0]  m_ptr = 8'h00;
  logic [15:0] wq[$];
  logic [15:0] wlog[$];
  logic        may_drive = 1'b0;
  logic        prev_we = 1'b0;

  always #5 clk = ~clk;

  assign sda_line  = sda_m & ~sda_oe;
  assign reg_rdata = reg_addr + 8'h40;

  i2c_target_regs #(.DEV_ADDR(7'h3C), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .scl_in(scl_m), .sda_in(sda_line),
    .sda_oe(sda_oe), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_rdata(reg_rdata), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (reg_we) begin
        check("we_expected", 32'(wq.size() > 0), 32'd1);
        check("we_single_cycle", 32'(prev_we), 32'd0);
        if (wq.size() > 0) check("we_addr_data", 32'({reg_addr, reg_wdata}), 32'(wq.pop_front()));
        wlog.push_back({reg_addr, reg_wdata});
      end
      if (!may_drive) check("sda_oe_released", 32'(sda_oe), 32'd0);
    end
    prev_we = reg_we;
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic clock_bit(input logic b, input logic drive_next, output logic s);
    sda_m = b;
    wait_q();
    scl_m = 1'b1;
    wait_q();
    s = sda_line;
    wait_q();
    scl_m = 1'b0;
    if (drive_next) may_drive = 1'b1;
    wait_q();
    if (!drive_next) may_drive = 1'b0;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q(); wait_q();
  endtask

  task automatic send_byte(input string name, input logic [7:0] d, input logic exp_ack,
                           input logic read_follows);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], (i == 0) && exp_ack, s);
    clock_bit(1'b1, exp_ack && read_follows, s);
    check(name, 32'(!s), 32'(exp_ack));
  endtask

  // Model side of a data byte: the target writes it at the current pointer, then advances.
  task automatic write_byte(input string name, input logic [7:0] d);
    wq.push_back({m_ptr, d});
    m_ptr = m_ptr + 8'd1;
    send_byte(name, d, 1'b1, 1'b0);
  endtask

  task automatic recv_byte(input logic master_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, i != 0, s);
      d[i] = s;
    end
    clock_bit(!master_ack, master_ack, s);
  endtask

  task automatic read_byte(input string name, input logic master_ack, output logic [7:0] d);
    logic [7:0] exp;
    exp = m_ptr + 8'h40;
    recv_byte(master_ack, d);
    check(name, 32'(d), 32'(exp));
    if (master_ack) m_ptr = m_ptr + 8'd1;
  endtask

  logic [7:0] rd0, rd1;
  logic       sb;

  initial begin
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_reg_addr", 32'(reg_addr), 32'h00);
    check("rst_reg_wdata", 32'(reg_wdata), 32'h00);
    check("rst_reg_we", 32'(reg_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Plain write: pointer 0x10, data 0xA5
    bus_start();
    check("w1_busy_after_start", 32'(busy), 32'd1);
    send_byte("w1_addr_ack", 8'h78, 1'b1, 1'b0);
    m_ptr = 8'h10;
    send_byte("w1_ptr_ack", 8'h10, 1'b1, 1'b0);
    write_byte("w1_data_ack", 8'hA5);
    bus_stop();
    check("w1_busy_after_stop", 32'(busy), 32'd0);
    check("w1_reg_addr_model", 32'(reg_addr), 32'(m_ptr));
    check("w1_reg_addr_lit", 32'(reg_addr), 32'h11);
    check("w1_writes_drained", 32'(wq.size()), 32'd0);
    check("w1_wlog_lit", 32'(wlog.size() > 0 ? wlog[wlog.size()-1] : 16'h0), 32'h10A5);

    // Pointer set, repeated START, two-byte read
    bus_start();
    send_byte("r_addr_w_ack", 8'h78, 1'b1, 1'b0);
    m_ptr = 8'h05;
    send_byte("r_ptr_ack", 8'h05, 1'b1, 1'b0);
    bus_start();
    send_byte("r_addr_r_ack", 8'h79, 1'b1, 1'b1);
    read_byte("r_byte0", 1'b1, rd0);
    read_byte("r_byte1", 1'b0, rd1);
    bus_stop();
    check("r_byte0_lit", 32'(rd0), 32'h45);
    check("r_byte1_lit", 32'(rd1), 32'h46);
    check("r_reg_addr_model", 32'(reg_addr), 32'(m_ptr));
    check("r_busy_after_stop", 32'(busy), 32'd0);

    // Wrong device address: no ACK, no write
    bus_start();
    send_byte("nack_wrong_addr", 8'h7A, 1'b0, 1'b0);
    check("nack_busy_mid", 32'(busy), 32'd1);
    bus_stop();
    check("nack_busy_after_stop", 32'(busy), 32'd0);
    check("nack_reg_addr", 32'(reg_addr), 32'(m_ptr));
    check("nack_writes_drained", 32'(wq.size()), 32'd0);

    // Pointer wrap during a burst write
    wlog.delete();
    bus_start();
    send_byte("wrap_addr_ack", 8'h78, 1'b1, 1'b0);
    m_ptr = 8'hFF;
    send_byte("wrap_ptr_ack", 8'hFF, 1'b1, 1'b0);
    write_byte("wrap_d0_ack", 8'h11);
    write_byte("wrap_d1_ack", 8'h22);
    bus_stop();
    check("wrap_wlog_count", 32'(wlog.size()), 32'd2);
    check("wrap_wlog0_lit", 32'(wlog.size() > 0 ? wlog[0] : 16'h0), 32'hFF11);
    check("wrap_wlog1_lit", 32'(wlog.size() > 1 ? wlog[1] : 16'h0), 32'h0022);
    check("wrap_reg_addr_lit", 32'(reg_addr), 32'h01);
    check("wrap_writes_drained", 32'(wq.size()), 32'd0);

    // Reset during the 4th data bit of 0xB5 (that bit is 1, so the bus looks idle on release)
    wlog.delete();
    bus_start();
    send_byte("rst_mid_addr_ack", 8'h78, 1'b1, 1'b0);
    m_ptr = 8'h20;
    send_byte("rst_mid_ptr_ack", 8'h20, 1'b1, 1'b0);
    clock_bit(1'b1, 1'b0, sb);
    clock_bit(1'b0, 1'b0, sb);
    clock_bit(1'b1, 1'b0, sb);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1;
    repeat (Q / 2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    m_ptr = 8'h00;
    check("rst_mid_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_mid_reg_we", 32'(reg_we), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_reg_addr", 32'(reg_addr), 32'h00);
    repeat (Q - Q / 2 - 1) @(negedge clk);
    wait_q();
    scl_m = 1'b0; wait_q();
    clock_bit(1'b0, 1'b0, sb);
    clock_bit(1'b1, 1'b0, sb);
    clock_bit(1'b0, 1'b0, sb);
    clock_bit(1'b1, 1'b0, sb);
    clock_bit(1'b1, 1'b0, sb);
    check("rst_mid_no_ack", 32'(sb), 32'd1);
    check("rst_mid_busy_ignored", 32'(busy), 32'd0);
    bus_stop();
    check("rst_mid_no_write", 32'(wlog.size()), 32'd0);
    bus_start();
    send_byte("post_rst_addr_ack", 8'h78, 1'b1, 1'b0);
    m_ptr = 8'h30;
    send_byte("post_rst_ptr_ack", 8'h30, 1'b1, 1'b0);
    write_byte("post_rst_data_ack", 8'h5A);
    bus_stop();
    check("post_rst_wlog_lit", 32'(wlog.size() > 0 ? wlog[0] : 16'h0), 32'h305A);
    check("post_rst_reg_addr", 32'(reg_addr), 32'h31);
    check("post_rst_writes_drained", 32'(wq.size()), 32'd0);

`ifdef I2C_TGT_GLITCH_FILTER_EN
    // One-clock low blip on sdata with scl high must not look like START
    repeat (4) @(negedge clk);
    sda_m = 1'b0;
    @(negedge clk);
    sda_m = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_no_start", 32'(busy), 32'd0);
    send_byte("glitch_no_ack", 8'h78, 1'b0, 1'b0);
    bus_stop();
    check("glitch_no_write", 32'(wq.size()), 32'd0);
`endif

    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/i2c_target_regs.md
I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

Interface
REQ-001 The block SHALL use parameter DEV_ADDR, default 7'h3C, meaning the 7-bit I2C device address it responds to.
REQ-002 The block SHALL use parameter SYNC_STAGES, default 2, meaning the number of flops in the scl/sda input synchronizers (legal range 2..3).
REQ-003 The block SHALL have port clk, input, 1, meaning the chip clock, which is the only clock.
REQ-004 The block SHALL have port reset_n, input, 1, meaning the chip reset, which is synchronous and active-low.
REQ-005 The block SHALL have port scl_in, input, 1, meaning the sampled sclk bus level.
REQ-006 The block SHALL have port sda_in, input, 1, meaning the sampled sdata bus level.
REQ-007 The block SHALL have port sda_oe, output, 1, where 1 pulls sdata low and 0 releases it (open drain; the block never drives high).
REQ-008 The block SHALL have port reg_addr, output, 8, meaning the register pointer.
REQ-009 The block SHALL have port reg_wdata, output, 8, meaning the write data.
REQ-010 The block SHALL have port reg_we, output, 1, meaning a single-cycle write strobe.
REQ-011 The block SHALL have port reg_rdata, input, 8, meaning the read data for reg_addr, valid combinationally.
REQ-012 The block SHALL have port busy, output, 1, which is high from START until STOP.

Function
REQ-013 The block SHALL pass scl_in and sda_in through SYNC_STAGES flops, and all edge detection SHALL use only the synchronized values.
REQ-014 The block SHALL detect START (and repeated START) as a falling edge on synchronized sda while scl is high, and STOP as a rising edge on synchronized sda while scl is high.
REQ-015 The block SHALL provide states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
REQ-016 A START in any state SHALL go to ADDR with the bit counter cleared, and a STOP in any state SHALL go to IDLE with sda_oe=0.
REQ-017 The block SHALL shift data bits MSB-first on the scl rising edge and update sda_oe only on the scl falling edge.
REQ-018 In ADDR, the block SHALL compare the first 7 bits to DEV_ADDR after 8 bits have been received; on a mismatch it SHALL go to IDLE without ACK, and on a match it SHALL go to ADDR_ACK, driving sda_oe=1 for one scl period.
REQ-019 After ADDR_ACK, R/W=0 SHALL go to PTR and R/W=1 SHALL go to RDATA.
REQ-020 Every PTR byte SHALL be loaded into reg_addr and ACKed (PTR_ACK); the block SHALL then go to WDATA.
REQ-021 Each completed WDATA byte SHALL drive reg_wdata and assert reg_we for exactly one clk cycle, 1 cycle after the 8th synchronized scl rise; the block SHALL then ACK (WDATA_ACK) and increment reg_addr.
REQ-022 On entering RDATA, the block SHALL capture reg_rdata into the shift register on the scl falling edge and drive bit 7 on that edge, with sda_oe equal to the inverse of the data bit.
REQ-023 In RDATA_ACK, the block SHALL release sda and sample the master's bit; ACK (0) SHALL increment reg_addr and return to RDATA, and NACK (1) SHALL go to IDLE-wait (sda released until STOP/START).
REQ-024 reg_addr SHALL wrap 8'hFF to 8'h00 on increment.
REQ-025 A STOP during WDATA before the 8th bit SHALL drop the partial byte with no reg_we.
REQ-026 If START and STOP are detected in the same cycle (impossible on legal bus), START SHALL take priority.

Reset
REQ-027 While reset_n=0 at a clk edge, the block SHALL reset to state IDLE, sda_oe=0, reg_addr=8'h00, reg_wdata=8'h00, reg_we=0, and busy=0, with the synchronizers set to 1 (idle bus).
REQ-028 Reset asserted mid-transfer SHALL release sda within the same cycle in which the reset takes effect, and the block SHALL ignore bus traffic until the next START.

Configuration
REQ-029 The block SHALL support macro I2C_TGT_GLITCH_FILTER_EN; when it is defined, each synchronized line SHALL pass a 3-sample majority filter, which adds 2 clk cycles of latency to all detection and to reg_we timing.
REQ-030 When I2C_TGT_GLITCH_FILTER_EN is undefined, no filter SHALL be present, and the timing of REQ-021 SHALL hold as written.

Verification
REQ-031 The bench SHALL cover: START, 0x78 (addr 0x3C W), 0x10, 0xA5, STOP -> three ACKs, one reg_we with reg_addr=0x10 and reg_wdata=0xA5, and final reg_addr=0x11.
REQ-032 The bench SHALL cover: START, 0x78, 0x05, repeated START, 0x79, read 2 bytes with ACK then NACK, with reg_rdata=reg_addr+0x40 -> bytes 0x45 and 0x46 on the bus.
REQ-033 The bench SHALL cover: START, 0x7A (wrong addr) -> no ACK (sdata high at 9th clock), busy low after STOP, and no reg_we.
REQ-034 The bench SHALL cover: pointer 0xFF with burst write of 0x11, 0x22 -> writes at 0xFF then 0x00.
REQ-035 The bench SHALL cover: reset_n low during the 4th data bit of a write -> sda_oe=0 next cycle, no reg_we, and the following transaction is correct.
REQ-036 The bench SHALL cover: with I2C_TGT_GLITCH_FILTER_EN, a 1-clk low pulse on sdata while scl is high -> no START/STOP detected.
